// File: rtl/flag_win_pkg.sv
// rtl/flag_win_pkg.sv - shared types and defaults for the flag window counter
package flag_win_pkg;

  typedef enum logic {
    FW_IDLE  = 1'b0,
    FW_COUNT = 1'b1
  } fw_state_t;

  localparam int FW_WIN_LEN_DEF = 16;
  localparam int FW_CNT_W_DEF   = 8;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with sticky saturation flag
// q/sat already include this cycle's increment, so a clearing edge still reports its last event.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         sat
);

  logic [W-1:0] cnt_q;
  logic         sat_q;

  always_comb begin
    q   = cnt_q;
    sat = sat_q;
    if (inc) begin
      if (&cnt_q) begin
        sat = 1'b1;
      end else begin
        q = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (clr) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= q;
      sat_q <= sat;
    end
  end

endmodule

// File: rtl/flag_window_counter.sv
// rtl/flag_window_counter.sv - counts flag strobes per WIN_LEN-cycle window
// Results are offered on a valid/ready port; a window ending while one is pending is dropped.
module flag_window_counter
  import flag_win_pkg::*;
#(
  parameter int WIN_LEN = FW_WIN_LEN_DEF,
  parameter int CNT_W   = FW_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flag,
  input  logic             enable,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lost,
  output logic             busy
);

  localparam int              WC_W    = $clog2(WIN_LEN);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WIN_LEN - 1);

  fw_state_t        state_q, state_d;
  logic [WC_W-1:0]  win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_sat_q, out_sat_d;
  logic             out_valid_q, out_valid_d;
  logic             lost_q, lost_d;

  logic             counting, win_end, handshake;
  logic [CNT_W-1:0] ev_cnt;
  logic             ev_sat;

  assign counting  = (state_q == FW_COUNT) && enable;
  assign win_end   = counting && (win_cnt_q == WC_LAST);
  assign handshake = out_valid_q && out_ready;

  // Clearing outside COUNT means re-entry always starts a fresh window.
  sat_counter #(.W(CNT_W)) u_ev_cnt (
    .clk (clk),
    .rst (rst),
    .clr (!counting || win_end),
    .inc (counting && flag),
    .q   (ev_cnt),
    .sat (ev_sat)
  );

  always_comb begin
    state_d     = enable ? FW_COUNT : FW_IDLE;
    win_cnt_d   = (!counting || win_end) ? '0 : win_cnt_q + WC_W'(1);
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;
    lost_d      = 1'b0;
    if (win_end) begin
      if (!out_valid_q || handshake) begin
        out_count_d = ev_cnt;
        out_sat_d   = ev_sat;
        out_valid_d = 1'b1;
      end else begin
        lost_d = 1'b1;
      end
    end else if (handshake) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FW_IDLE;
      win_cnt_q   <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
      lost_q      <= lost_d;
    end
  end

  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;
  assign out_valid = out_valid_q;
  assign lost      = lost_q;
  assign busy      = (state_q == FW_COUNT);

endmodule

// File: tb/tb_flag_window_counter.sv
// tb/tb_flag_window_counter.sv - self-checking bench for flag_window_counter
module tb_flag_window_counter;

  localparam int WIN = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flag = 1'b0, enable = 1'b0, out_ready = 1'b0;
  logic [7:0] count8;
  logic [2:0] count3;
  logic       sat8, sat3, valid8, valid3, lost8, lost3, busy8, busy3;

  int checks = 0;
  int errors = 0;

  // Reference model: raw flag totals per window, saturation applied when compared.
  bit m_run;
  int m_pos, m_flags;
  bit e_valid, e_lost;
  int e_raw;

  always #5 clk = ~clk;

  flag_window_counter #(.WIN_LEN(WIN), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .flag(flag), .enable(enable),
    .out_count(count8), .out_sat(sat8), .out_valid(valid8),
    .out_ready(out_ready), .lost(lost8), .busy(busy8)
  );

  flag_window_counter #(.WIN_LEN(WIN), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .flag(flag), .enable(enable),
    .out_count(count3), .out_sat(sat3), .out_valid(valid3),
    .out_ready(out_ready), .lost(lost3), .busy(busy3)
  );

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_flags = 0;
    e_valid = 0; e_lost = 0; e_raw = 0;
  endtask

  task automatic model_step(input bit en, input bit fl, input bit rdy);
    bit hs;
    bit done;
    int raw;
    hs = e_valid && rdy;
    done = 0;
    raw = 0;
    e_lost = 0;
    if (!m_run) begin
      if (en) begin m_run = 1; m_pos = 0; m_flags = 0; end
    end else if (!en) begin
      m_run = 0;
    end else begin
      m_flags += int'(fl);
      m_pos++;
      if (m_pos == WIN) begin done = 1; raw = m_flags; m_pos = 0; m_flags = 0; end
    end
    if (done) begin
      if (!e_valid || hs) begin e_valid = 1; e_raw = raw; end
      else e_lost = 1;
    end else if (hs) begin
      e_valid = 0;
    end
  endtask

  task automatic cyc(input bit en, input bit fl, input bit rdy);
    enable = en; flag = fl; out_ready = rdy;
    model_step(en, fl, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic run_window(input int nf, input bit rdy, input bit rdy_end);
    for (int k = 1; k <= WIN; k++) cyc(1'b1, k <= nf, (k == WIN) ? rdy_end : rdy);
  endtask

  task automatic test_reset();
    rst = 0; enable = 0; flag = 0; out_ready = 0;
    model_reset();
    #3;
    checks++; if (valid8 !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", valid8); end
    checks++; if (count8 !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count8); end
    checks++; if ({sat8, lost8, busy8} !== 3'b000) begin errors++; $display("FAIL reset_sat_lost_busy got %b exp 000", {sat8, lost8, busy8}); end
    @(posedge clk);
    #3 rst = 1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
    checks++; if ({busy8, valid8} !== 2'b00) begin errors++; $display("FAIL idle_after_reset got %b exp 00", {busy8, valid8}); end
  endtask

  task automatic test_basic();
    cyc(1'b1, 1'b1, 1'b1);
    checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL basic_busy got %0b exp 1", busy8); end
    for (int k = 1; k <= WIN; k++) begin
      cyc(1'b1, (k == 3) || (k == 8) || (k == 16), 1'b1);
      if (k == WIN - 1) begin
        checks++; if (valid8 !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0b exp 0", valid8); end
      end
    end
    checks++; if (valid8 !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b exp 1", valid8); end
    checks++; if (count8 !== 8'd3) begin errors++; $display("FAIL basic_count got %0d exp 3", count8); end
    checks++; if (sat8 !== 1'b0) begin errors++; $display("FAIL basic_sat got %0b exp 0", sat8); end
    cyc(1'b0, 1'b0, 1'b1);
    checks++; if ({valid8, busy8} !== 2'b00) begin errors++; $display("FAIL basic_after got %b exp 00", {valid8, busy8}); end
  endtask

  task automatic test_saturate();
    cyc(1'b1, 1'b1, 1'b1);
    for (int w = 0; w < 2; w++) begin
      run_window(WIN, 1'b1, 1'b1);
      checks++; if ({valid3, count3, sat3} !== {1'b1, 3'd7, 1'b1}) begin errors++; $display("FAIL sat3_win%0d got v%0b c%0d s%0b exp v1 c7 s1", w, valid3, count3, sat3); end
      checks++; if ({count8, sat8} !== {8'd16, 1'b0}) begin errors++; $display("FAIL sat8_win%0d got c%0d s%0b exp c16 s0", w, count8, sat8); end
    end
    cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    cyc(1'b1, 1'b0, 1'b0);
    run_window(2, 1'b0, 1'b0);
    checks++; if ({valid8, count8, lost8} !== {1'b1, 8'd2, 1'b0}) begin errors++; $display("FAIL bp_first got v%0b c%0d l%0b exp v1 c2 l0", valid8, count8, lost8); end
    run_window(5, 1'b0, 1'b0);
    checks++; if ({valid8, count8, lost8} !== {1'b1, 8'd2, 1'b1}) begin errors++; $display("FAIL bp_drop got v%0b c%0d l%0b exp v1 c2 l1", valid8, count8, lost8); end
    cyc(1'b1, 1'b0, 1'b1);
    checks++; if ({valid8, count8, lost8} !== {1'b0, 8'd2, 1'b0}) begin errors++; $display("FAIL bp_deliver got v%0b c%0d l%0b exp v0 c2 l0", valid8, count8, lost8); end
    for (int k = 2; k <= WIN; k++) cyc(1'b1, k == 5, 1'b1);
    checks++; if ({valid8, count8} !== {1'b1, 8'd1}) begin errors++; $display("FAIL bp_next got v%0b c%0d exp v1 c1", valid8, count8); end
    cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_hs_at_end();
    cyc(1'b1, 1'b0, 1'b0);
    run_window(4, 1'b0, 1'b0);
    for (int k = 1; k < WIN; k++) cyc(1'b1, k <= 6, 1'b0);
    checks++; if (count8 !== 8'd4) begin errors++; $display("FAIL hs_hold got %0d exp 4", count8); end
    cyc(1'b1, 1'b0, 1'b1);
    checks++; if ({valid8, count8, lost8} !== {1'b1, 8'd6, 1'b0}) begin errors++; $display("FAIL hs_end got v%0b c%0d l%0b exp v1 c6 l0", valid8, count8, lost8); end
    cyc(1'b0, 1'b0, 1'b1);
    checks++; if ({valid8, lost8, busy8} !== 3'b000) begin errors++; $display("FAIL hs_after got %b exp 000", {valid8, lost8, busy8}); end
  endtask

  task automatic test_stop();
    int seen;
    cyc(1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) cyc(1'b1, k <= 3, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    checks++; if ({busy8, valid8} !== 2'b00) begin errors++; $display("FAIL stop_idle got %b exp 00", {busy8, valid8}); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin cyc(1'b0, 1'b1, 1'b1); seen += int'(valid8); end
    checks++; if (seen !== 0) begin errors++; $display("FAIL stop_no_result got %0d exp 0", seen); end
    cyc(1'b1, 1'b1, 1'b1);
    run_window(2, 1'b1, 1'b1);
    checks++; if ({valid8, count8} !== {1'b1, 8'd2}) begin errors++; $display("FAIL stop_fresh got v%0b c%0d exp v1 c2", valid8, count8); end
    for (int k = 1; k < WIN; k++) cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    checks++; if ({valid8, busy8, lost8} !== 3'b000) begin errors++; $display("FAIL stop_at_end got %b exp 000", {valid8, busy8, lost8}); end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 1'b0, 1'b0);
    run_window(3, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) cyc(1'b1, 1'b1, 1'b0);
    #2 rst = 0;
    model_reset();
    #1;
    checks++; if ({valid8, count8, sat8, lost8, busy8} !== 12'd0) begin errors++; $display("FAIL rst_mid8 got v%0b c%0d s%0b l%0b b%0b exp all 0", valid8, count8, sat8, lost8, busy8); end
    checks++; if ({valid3, count3, busy3} !== 5'd0) begin errors++; $display("FAIL rst_mid3 got v%0b c%0d b%0b exp all 0", valid3, count3, busy3); end
    @(posedge clk);
    #4 rst = 1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL rst_stay_idle got %0b exp 0", busy8); end
    cyc(1'b1, 1'b0, 1'b1);
    checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL rst_reenable got %0b exp 1", busy8); end
    cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    bit en, fl, rdy;
    int e8, e3;
    for (int i = 0; i < 3000; i++) begin
      en  = ($urandom_range(0, 63) != 0);
      fl  = $urandom_range(0, 1) == 1;
      rdy = ($urandom_range(0, 9) < 7);
      cyc(en, fl, rdy);
      e8 = (e_raw > 255) ? 255 : e_raw;
      e3 = (e_raw > 7) ? 7 : e_raw;
      checks++; if ({valid8, lost8, busy8} !== {e_valid, e_lost, m_run}) begin errors++; $display("FAIL rnd_ctrl8 cyc %0d got %b exp %b", i, {valid8, lost8, busy8}, {e_valid, e_lost, m_run}); end
      checks++; if ({valid3, lost3, busy3} !== {e_valid, e_lost, m_run}) begin errors++; $display("FAIL rnd_ctrl3 cyc %0d got %b exp %b", i, {valid3, lost3, busy3}, {e_valid, e_lost, m_run}); end
      checks++; if ({count8, sat8} !== {8'(e8), e_raw > 255}) begin errors++; $display("FAIL rnd_res8 cyc %0d got c%0d s%0b exp c%0d s%0b", i, count8, sat8, e8, e_raw > 255); end
      checks++; if ({count3, sat3} !== {3'(e3), e_raw > 7}) begin errors++; $display("FAIL rnd_res3 cyc %0d got c%0d s%0b exp c%0d s%0b", i, count3, sat3, e3, e_raw > 7); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_backpressure();
    test_hs_at_end();
    test_stop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flag_window_counter.md
# flag_window_counter

Downstream consumer of the sequence-detector `flag` output. It counts flag pulses over fixed windows of `WIN_LEN` clock cycles and presents each window's total on a valid/ready result port. It sits between the detector FSM and the status/statistics logic. It converts single-cycle detection strobes into per-window event rates, with saturation and lost-result reporting.

## Interface
- `WIN_LEN`, 16: window length in clk cycles; legal range ≥ 2.
- `CNT_W`, 8: width of the event count.
- `clk`  in  1  system clock; all sampling is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flag`  in  1  detector strobe; driven combinationally by the upstream FSM and sampled at the clk edge only.
- `enable`  in  1  run/stop. While low, the block stays in IDLE and counts nothing.
- `out_count`  out  CNT_W  flag count of the last completed window.
- `out_sat`  out  1  set when that window's count saturated.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `lost`  out  1  one-cycle pulse when a completed window is dropped.
- `busy`  out  1  high while in COUNT.

## Operation
- FSM states:
  - IDLE → COUNT when `enable`=1 is sampled.
  - COUNT → IDLE when `enable`=0 is sampled. The partial window is discarded and no result is produced.
- Internal counters:
  - `win_cnt` runs 0..WIN_LEN-1 and wraps.
  - `ev_cnt` (CNT_W bits) is the running event count.
  - `sat` is the sticky saturation bit for the current window.
- On each COUNT edge with `flag`=1:
  - `ev_cnt` increments, saturating at 2^CNT_W-1.
  - A flag arriving when `ev_cnt` is already at max sets `sat`.
- Window end is the COUNT edge where `win_cnt`=WIN_LEN-1:
  - The final count includes that edge's flag.
  - `ev_cnt`, `sat` and `win_cnt` restart at 0 on the same edge, so consecutive windows have no gap cycle.
- Result register (`out_count`, `out_sat`, `out_valid`):
  - A handshake completes on an edge with `out_valid`&&`out_ready`.
  - At window end, if `out_valid`=0, or a handshake completes on that same edge, the new result loads and `out_valid` is 1 afterwards.
  - At window end, if `out_valid`=1 and `out_ready`=0, the pending result is held and the new one is dropped; `lost` pulses for one cycle.
  - A handshake with no window end clears `out_valid`. `out_count` and `out_sat` keep their last value.
- A pending result survives a transition to IDLE and is still delivered via handshake.
- `out_count`, `out_sat` and `out_valid` do not change while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values:
  - Outputs: `out_count`=0, `out_sat`=0, `out_valid`=0, `lost`=0, `busy`=0.
  - Internal: state IDLE, `win_cnt`=0, `ev_cnt`=0.
- Reset mid-window or with a pending result discards everything immediately, asynchronously.
- Window timing, with `enable` first sampled high at edge E0:
  - COUNT is entered and `busy`=1 after E0. The flag at E0 is not counted.
  - Counted edges are E1..E(WIN_LEN).
  - The result is registered at E(WIN_LEN), and `out_valid` is high in the following cycle.
- Latency from the last counted flag to `out_valid`: 1 cycle.
- `enable` dropping at the window-end edge: counted as a stop. No result is produced and the state goes to IDLE.
- `lost` is registered and is high for exactly the cycle after the dropping edge.
- Steady state: one result every WIN_LEN cycles.

## Structure
- Package `flag_win_pkg`:
  - state typedef `fw_state_t` {FW_IDLE, FW_COUNT};
  - default constants `FW_WIN_LEN_DEF`=16 and `FW_CNT_W_DEF`=8.
- Sub-module `sat_counter` (parameter W; inputs clr, inc; outputs q, sat):
  - instantiated once for `ev_cnt`/`sat`;
  - `clr` has priority over `inc`, with the final increment folded into the result path.
- The window counter and result register stay inline.

## Test plan
- Reset, then `enable`=1, `out_ready`=1, flag high on counted edges 3, 8 and 16 (WIN_LEN=16) → `out_valid` for 1 cycle after E16, `out_count`=3, `out_sat`=0.
- `flag` held 1 continuously with CNT_W=3, WIN_LEN=16 → every window reports `out_count`=7, `out_sat`=1. The next window restarts from 0 with no missed edge.
- `out_ready`=0 across two window ends (counts 2 then 5) → `out_count` stays 2, `lost` pulses once after the second end. Raising `out_ready` delivers 2; the next window's result then loads.
- Handshake on the exact window-end edge (pending 4, new 6) → `out_valid` stays 1, `out_count`=6, no `lost`.
- `enable` dropped at counted edge 9 with 3 flags seen → IDLE, `busy`=0, no result. Re-enable starts a fresh 16-cycle window reporting only new flags.
- `rst` asserted mid-window with a pending result → all outputs 0 immediately. After release, the block stays IDLE until `enable` is sampled high.
